cpu_run_controller: RTL and testbench



---
 rtl/cpu_run_controller.sv | 94 +++++++++
 tb/tb_cpu_run_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run controller: holds the core in reset, then supervises RUN until halt or watchdog.
// Optional stall counter built when RUN_CTRL_STALL_COUNT_EN is defined.
module cpu_run_controller #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 200,
  parameter int MAX_CYCLES   = 100000,
  parameter int HALT_STABLE  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             inst_valid,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [PC_W-1:0]  final_pc,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int HOLD_W   = $clog2(RESET_CYCLES + 1);
  localparam int STABLE_W = $clog2(HALT_STABLE) + 1;

  typedef enum logic [1:0] {HOLD, RUN, DONE, TIMEOUT} state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STABLE_W-1:0] stable_cnt;
  logic [PC_W-1:0]     pc_q;
  logic                pc_q_valid;
  logic                pc_eq, halt_cond, wdog_cond;

  assign pc_eq     = pc_q_valid && (pc == pc_q);
  assign halt_cond = halt_req || (pc_eq && stable_cnt == STABLE_W'(HALT_STABLE - 1));
  // Halt has priority over the watchdog when both fire on the same cycle.
  assign wdog_cond = !halt_cond && (cycle_count == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      stable_cnt    <= '0;
      pc_q          <= '0;
      pc_q_valid    <= 1'b0;
      cpu_reset     <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
      final_pc      <= '0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (inst_valid) retired_count <= retired_count + 1'b1;
          pc_q       <= pc;
          pc_q_valid <= 1'b1;
          stable_cnt <= pc_eq ? stable_cnt + 1'b1 : '0;
          if (halt_cond || wdog_cond) begin
            state    <= halt_cond ? DONE : TIMEOUT;
            final_pc <= pc;
            running  <= 1'b0;
            done     <= halt_cond;
            timeout  <= wdog_cond;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_CTRL_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == RUN && !inst_valid && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with RESET_CYCLES=4, MAX_CYCLES=20, HALT_STABLE=3.
module tb_cpu_run_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        inst_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_reset, running, done, timeout;
  logic [31:0] cycle_count, retired_count, final_pc, stall_cycles;
  int          n_tests = 0;
  int          n_fail = 0;

  cpu_run_controller #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(4), .MAX_CYCLES(20), .HALT_STABLE(3)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst_valid(inst_valid), .halt_req(halt_req),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .retired_count(retired_count), .final_pc(final_pc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef RUN_CTRL_STALL_COUNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reset then walk through HOLD, leaving the DUT at the start of RUN.
  task automatic enter_run();
    reset = 1'b1; halt_req = 1'b0; inst_valid = 1'b0; pc = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; halt_req = 1'b0; inst_valid = 1'b0; pc = 32'h100;
    repeat (3) step();
    n_tests++;
    if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 ||
        cycle_count !== 0 || retired_count !== 0 || final_pc !== 0 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL reset_values: cpu_reset=%b running=%b done=%b timeout=%b cc=%0d rc=%0d fpc=%h st=%0d, want 1 0 0 0 0 0 0 0",
               cpu_reset, running, done, timeout, cycle_count, retired_count, final_pc, stall_cycles);
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if (cpu_reset !== (k < 4) || running !== (k == 4)) begin
        n_fail++;
        $display("FAIL hold_edge%0d: cpu_reset=%b running=%b, want %b %b", k, cpu_reset, running, k < 4, k == 4);
      end
    end
    n_tests++;
    if (cycle_count !== 0 || retired_count !== 0) begin
      n_fail++;
      $display("FAIL run_entry_counts: cc=%0d rc=%0d, want 0 0", cycle_count, retired_count);
    end
  endtask

  task automatic test_pc_halt();
    enter_run();
    inst_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc = i * 4; step();
    end
    pc = 32'h40;
    repeat (3) step();
    n_tests++;
    if (done !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_early: done=%b running=%b, want 0 1", done, running);
    end
    step();
    n_tests++;
    if (done !== 1'b1 || timeout !== 1'b0 || running !== 1'b0 || final_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL halt_selfloop: done=%b timeout=%b running=%b fpc=%h, want 1 0 0 40", done, timeout, running, final_pc);
    end
    n_tests++;
    if (cycle_count !== 20 || retired_count !== 20) begin
      n_fail++;
      $display("FAIL halt_counts: cc=%0d rc=%0d, want 20 20", cycle_count, retired_count);
    end
    inst_valid = 1'b0;
  endtask

  task automatic test_timeout();
    enter_run();
    inst_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      pc = i * 4; step();
    end
    n_tests++;
    if (timeout !== 1'b0 || cycle_count !== 19) begin
      n_fail++;
      $display("FAIL timeout_early: timeout=%b cc=%0d, want 0 19", timeout, cycle_count);
    end
    pc = 19 * 4; step();
    n_tests++;
    if (timeout !== 1'b1 || done !== 1'b0 || running !== 1'b0 || cycle_count !== 20 || final_pc !== 32'h4C) begin
      n_fail++;
      $display("FAIL timeout_fire: timeout=%b done=%b running=%b cc=%0d fpc=%h, want 1 0 0 20 4c",
               timeout, done, running, cycle_count, final_pc);
    end
    halt_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h200 + i * 4; step();
    end
    n_tests++;
    if (timeout !== 1'b1 || done !== 1'b0 || cycle_count !== 20 || retired_count !== 20 ||
        final_pc !== 32'h4C || cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_frozen: timeout=%b done=%b cc=%0d rc=%0d fpc=%h cpu_reset=%b, want 1 0 20 20 4c 0",
               timeout, done, cycle_count, retired_count, final_pc, cpu_reset);
    end
    halt_req = 1'b0; inst_valid = 1'b0;
  endtask

  task automatic test_halt_vs_timeout();
    enter_run();
    for (int i = 0; i < 19; i++) begin
      pc = i * 4; step();
    end
    halt_req = 1'b1; pc = 32'h4C; step();
    halt_req = 1'b0;
    n_tests++;
    if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 20 || retired_count !== 0) begin
      n_fail++;
      $display("FAIL halt_wins: done=%b timeout=%b cc=%0d rc=%0d, want 1 0 20 0", done, timeout, cycle_count, retired_count);
    end
  endtask

  task automatic test_mid_reset();
    enter_run();
    inst_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = i * 4; step();
    end
    reset = 1'b1; pc = 32'h18; step();
    n_tests++;
    if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== 0 || retired_count !== 0 || final_pc !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: cpu_reset=%b running=%b cc=%0d rc=%0d fpc=%h, want 1 0 0 0 0",
               cpu_reset, running, cycle_count, retired_count, final_pc);
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if (cpu_reset !== (k < 4) || running !== (k == 4) || cycle_count !== 0) begin
        n_fail++;
        $display("FAIL rehold_edge%0d: cpu_reset=%b running=%b cc=%0d, want %b %b 0",
                 k, cpu_reset, running, cycle_count, k < 4, k == 4);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pc = 32'h80 + i * 4; step();
    end
    n_tests++;
    if (cycle_count !== 3 || retired_count !== 3 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_count: cc=%0d rc=%0d running=%b, want 3 3 1", cycle_count, retired_count, running);
    end
    inst_valid = 1'b0;
  endtask

  task automatic test_stall();
    enter_run();
    for (int i = 0; i < 10; i++) begin
      pc = i * 4; inst_valid = (i % 2 == 0); halt_req = (i == 9);
      step();
      n_tests++;
      if (stall_cycles !== ((STALL_EXP == 0) ? 0 : (i + 1) / 2)) begin
        n_fail++;
        $display("FAIL stall_run%0d: stall=%0d, want %0d", i, stall_cycles, (STALL_EXP == 0) ? 0 : (i + 1) / 2);
      end
    end
    halt_req = 1'b0; inst_valid = 1'b0;
    repeat (3) step();
    n_tests++;
    if (done !== 1'b1 || stall_cycles !== STALL_EXP || retired_count !== 5 || cycle_count !== 10) begin
      n_fail++;
      $display("FAIL stall_final: done=%b stall=%0d rc=%0d cc=%0d, want 1 %0d 5 10",
               done, stall_cycles, retired_count, cycle_count, STALL_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_pc_halt();
    test_timeout();
    test_halt_vs_timeout();
    test_mid_reset();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
